cond_issue_ctrl: RTL

Sequencing controller for conditionally executed ALU operations. It holds the architectural NZCV flag register and accepts one operation at a time over a valid/ready handshake. It evaluates the operation's 4-bit condition code against the stored flags, and either issues the operation to the ALU and waits for completion or skips it. It then updates the flags and returns a response. It sits between instruction decode and the ALU/CMP datapath.

---
 rtl/cond_issue_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cond_issue_ctrl.sv
// cond_issue_ctrl: conditional-execution sequencer holding the NZCV flags.
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/ready/op/in1/in2/cond/setflags/tag : operation request (accepted in IDLE)
//   alu_valid/op/in1/in2       : one-cycle issue to the ALU with registered operands
//   alu_done/result/flags      : ALU completion, only honoured while waiting
//   rsp_valid/ready/result/executed/error/tag : response, held until accepted
//   flags, flags_wr, flags_wdata : architectural NZCV register and its direct load
module cond_issue_ctrl #(
   parameter int DATA_W      = 32,
   parameter int OP_W        = 4,
   parameter int ALU_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [DATA_W-1:0] req_in1,
   input  logic [DATA_W-1:0] req_in2,
   input  logic [3:0]        req_cond,
   input  logic              req_setflags,
   input  logic [3:0]        req_tag,
   output logic              alu_valid,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   input  logic              alu_done,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_flags,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_executed,
   output logic              rsp_error,
   output logic [3:0]        rsp_tag,
   output logic [3:0]        flags,
   input  logic              flags_wr,
   input  logic [3:0]        flags_wdata
);
   localparam int CW = $clog2(ALU_TIMEOUT);
   typedef enum logic [2:0] {IDLE, EVAL, ISSUE, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic [3:0] flags_q, flags_d, cond_q, cond_d, tag_q, tag_d;
   logic [OP_W-1:0] op_q, op_d;
   logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d, res_q, res_d;
   logic setf_q, setf_d, exec_q, exec_d, err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic cond_ok, cond_rsvd, fn, fz, fc, fv;
   assign {fn, fz, fc, fv} = flags_q;
   assign cond_rsvd = cond_q > 4'd8;
   always_comb begin
      case (cond_q)
         4'd0:    cond_ok = 1'b1;
         4'd1:    cond_ok = fz;
         4'd2:    cond_ok = !fz && fn == fv;
         4'd3:    cond_ok = fn != fv;
         4'd4:    cond_ok = fn == fv;
         4'd5:    cond_ok = fz || fn != fv;
         4'd6:    cond_ok = fc && !fz;
         4'd7:    cond_ok = !fc;
         4'd8:    cond_ok = fc;
         default: cond_ok = 1'b0;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         flags_q <= '0;
         cond_q  <= '0;
         tag_q   <= '0;
         op_q    <= '0;
         in1_q   <= '0;
         in2_q   <= '0;
         res_q   <= '0;
         setf_q  <= 1'b0;
         exec_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         cond_q  <= cond_d;
         tag_q   <= tag_d;
         op_q    <= op_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         res_q   <= res_d;
         setf_q  <= setf_d;
         exec_q  <= exec_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
   // A WAIT completion with setflags overrides a simultaneous direct flag load.
   always_comb begin
      state_d = state_q;
      flags_d = flags_wr ? flags_wdata : flags_q;
      cond_d  = cond_q;
      tag_d   = tag_q;
      op_d    = op_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      res_d   = res_q;
      setf_d  = setf_q;
      exec_d  = exec_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (req_valid) begin
            state_d = EVAL;
            cond_d  = req_cond;
            tag_d   = req_tag;
            op_d    = req_op;
            in1_d   = req_in1;
            in2_d   = req_in2;
            setf_d  = req_setflags;
         end
         EVAL: begin
            state_d = (cond_ok && !cond_rsvd) ? ISSUE : RESP;
            res_d   = '0;
            exec_d  = 1'b0;
            err_d   = cond_rsvd;
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         WAIT: if (alu_done) begin
            state_d = RESP;
            res_d   = alu_result;
            exec_d  = 1'b1;
            err_d   = 1'b0;
            flags_d = setf_q ? alu_flags : flags_d;
         end else if (cnt_q == CW'(ALU_TIMEOUT - 1)) begin
            state_d = RESP;
            res_d   = '0;
            exec_d  = 1'b0;
            err_d   = 1'b1;
         end else begin
            cnt_d   = cnt_q + 1'b1;
         end
         RESP: state_d = rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      req_ready = state_q == IDLE && !rst;
      alu_valid = state_q == ISSUE;
      rsp_valid = state_q == RESP;
   end
   assign alu_op       = op_q;
   assign alu_in1      = in1_q;
   assign alu_in2      = in2_q;
   assign rsp_result   = res_q;
   assign rsp_executed = exec_q;
   assign rsp_error    = err_q;
   assign rsp_tag      = tag_q;
   assign flags        = flags_q;
endmodule
